// File: rtl/out_port_display_pkg.sv
// Shared display definitions: active-low seven-segment glyphs for the hex
// digits, the blank pattern, the all-anodes-off pattern and a helper that
// builds the one-hot-low anode select.
package out_port_display_pkg;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [7:0] ANODE_OFF = 8'hFF;

  // Drive the selected digit's anode low, all others high.
  function automatic logic [7:0] anode_sel(input logic [2:0] idx);
    return ~(8'h01 << idx);
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder with a blank
// override that turns every segment off.
module hex_to_7seg
  import out_port_display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  // Glyph lookup; blank wins over the nibble value.
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (nibble)
        4'h0:    seg = SEG_0;
        4'h1:    seg = SEG_1;
        4'h2:    seg = SEG_2;
        4'h3:    seg = SEG_3;
        4'h4:    seg = SEG_4;
        4'h5:    seg = SEG_5;
        4'h6:    seg = SEG_6;
        4'h7:    seg = SEG_7;
        4'h8:    seg = SEG_8;
        4'h9:    seg = SEG_9;
        4'hA:    seg = SEG_A;
        4'hB:    seg = SEG_B;
        4'hC:    seg = SEG_C;
        4'hD:    seg = SEG_D;
        4'hE:    seg = SEG_E;
        default: seg = SEG_F;
      endcase
    end
  end

endmodule

// File: rtl/out_port_display.sv
// Eight-digit multiplexed hex display for the CPU OutPort. Writes land in a
// shadow register and are committed to the visible register only when the
// scan wraps from the last digit back to digit 0, so a frame never mixes two
// values. Outputs are one pipeline stage behind the scan counters.
module out_port_display
  import out_port_display_pkg::*;
#(
  parameter int REFRESH_DIV   = 50000,
  parameter int NUM_DIGITS    = 8,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] out_data,
  input  logic        out_load,
  input  logic        enable,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  an,
  output logic        frame_done,
  output logic        pending
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRE_LAST   = PW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

  logic [PW-1:0] prescaler;
  logic [DW-1:0] digit_idx;
  logic [31:0]   shadow;
  logic [31:0]   display_reg;
  logic          tick;
  logic          wrap;
  logic [31:0]   shifted;
  logic          blank;
  logic [6:0]    seg_next;

  assign tick = enable && (prescaler == PRE_LAST);
  assign wrap = tick && (digit_idx == DIGIT_LAST);

  // The shifted word holds the current digit in its low nibble and every more
  // significant digit above it, so one zero test covers leading-zero blanking.
  assign shifted = display_reg >> {digit_idx, 2'b00};
  assign blank   = BLANK_LEADING && (digit_idx != '0) && (shifted == '0);

  hex_to_7seg u_dec (
    .nibble (shifted[3:0]),
    .blank  (blank),
    .seg    (seg_next)
  );

  // Prescaler and digit scan; both freeze while the scan is disabled.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      prescaler <= '0;
      digit_idx <= '0;
    end else if (enable) begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) begin
        digit_idx <= (digit_idx == DIGIT_LAST) ? '0 : digit_idx + 1'b1;
      end
    end
  end

  // Capture into shadow on every load; commit to the visible register on the
  // frame wrap. A load on the wrap tick itself keeps pending set.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      shadow      <= '0;
      display_reg <= '0;
      pending     <= 1'b0;
    end else begin
      if (wrap && pending) begin
        display_reg <= shadow;
      end
      if (out_load) begin
        shadow  <= out_data;
        pending <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
    end
  end

  // Output pipeline stage; anodes stay off for the first cycle of each slot
  // to hide the previous digit's segments while they change.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      an         <= ANODE_OFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= (!enable || prescaler == '0) ? ANODE_OFF : anode_sel(3'(digit_idx));
      seg        <= enable ? seg_next : SEG_BLANK;
      dp         <= !(enable && (digit_idx == '0) && pending);
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_out_port_display.sv
// Scoreboard bench for out_port_display. The driver applies one input set per
// cycle, predicts the registered outputs from an enabled-cycle count and the
// committed/shadow values, and queues the prediction; the monitor pops one
// prediction per clock edge and compares it with the outputs.
module tb_out_port_display;

  localparam int DIV = 4;

  logic        clock;
  logic        clear;
  logic [31:0] out_data;
  logic        out_load;
  logic        enable;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;
  logic        frame_done;
  logic        pending;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    logic       pend;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference state: enabled cycles since reset, committed and shadow values.
  int unsigned cnt;
  logic [31:0] m_disp;
  logic [31:0] m_shadow;
  logic        m_pend;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  out_port_display #(.REFRESH_DIV(DIV), .NUM_DIGITS(8), .BLANK_LEADING(1'b1)) dut (
    .clock      (clock),
    .clear      (clear),
    .out_data   (out_data),
    .out_load   (out_load),
    .enable     (enable),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done),
    .pending    (pending)
  );

  initial begin
    clock = 1'b1;
    forever #5 clock = ~clock;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    cnt      = 0;
    m_disp   = '0;
    m_shadow = '0;
    m_pend   = 1'b0;
  endtask

  // Called at a falling edge: drive inputs, queue the outputs expected after
  // the next rising edge, advance the model, wait for the next falling edge.
  task automatic step(input logic ld, input logic [31:0] d, input logic en);
    exp_t        e;
    int          pos;
    int          dig;
    logic        wrap;
    logic [31:0] upper;
    out_load = ld;
    out_data = d;
    enable   = en;
    pos   = int'(cnt % DIV);
    dig   = int'((cnt / DIV) % 8);
    wrap  = en && (pos == DIV - 1) && (dig == 7);
    upper = m_disp >> (4 * dig);
    e.an  = (!en || pos == 0) ? 8'hFF : ~(8'h01 << dig);
    e.seg = !en ? 7'h7F : ((dig != 0 && upper == 0) ? 7'h7F : glyph[upper[3:0]]);
    e.dp  = !(en && dig == 0 && m_pend);
    e.fd  = wrap;
    if (wrap && m_pend) m_disp = m_shadow;
    if (ld) begin
      m_shadow = d;
      m_pend   = 1'b1;
    end else if (wrap) begin
      m_pend = 1'b0;
    end
    e.pend = m_pend;
    if (en) cnt++;
    sb.push_back(e);
    @(negedge clock);
  endtask

  task automatic run_to(input int d, input int p);
    int n = 0;
    while (!(int'((cnt / DIV) % 8) == d && int'(cnt % DIV) == p) && n < 100) begin
      step(1'b0, 32'h0, 1'b1);
      n++;
    end
    check("run_to_reached", {31'b0, (int'((cnt / DIV) % 8) == d && int'(cnt % DIV) == p)}, 32'd1);
  endtask

  // Monitor: one queued prediction per rising edge, sampled just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("an",         {24'b0, an},         {24'b0, e.an});
        check("seg",        {25'b0, seg},        {25'b0, e.seg});
        check("dp",         {31'b0, dp},         {31'b0, e.dp});
        check("frame_done", {31'b0, frame_done}, {31'b0, e.fd});
        check("pending",    {31'b0, pending},    {31'b0, e.pend});
      end
    end
  end

  initial begin
    clear    = 1'b1;
    enable   = 1'b0;
    out_load = 1'b0;
    out_data = '0;
    reset_model();
    #22;
    check("rst_an",      {24'b0, an},         32'hFF);
    check("rst_seg",     {25'b0, seg},        32'h7F);
    check("rst_dp",      {31'b0, dp},         32'd1);
    check("rst_fd",      {31'b0, frame_done}, 32'd0);
    check("rst_pending", {31'b0, pending},    32'd0);
    @(negedge clock);
    clear = 1'b0;

    // Idle with scan disabled.
    repeat (200) step(1'b0, 32'h0, 1'b0);

    // Basic scan and commit.
    step(1'b1, 32'h1234ABCD, 1'b1);
    repeat (80) step(1'b0, 32'h0, 1'b1);

    // Leading-zero blanking.
    run_to(2, 1);
    step(1'b1, 32'h0000_00F0, 1'b1);
    repeat (80) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h0, 1'b1);
    repeat (80) step(1'b0, 32'h0, 1'b1);

    // Last write wins.
    run_to(2, 1);
    step(1'b1, 32'h11111111, 1'b1);
    repeat (3) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h22222222, 1'b1);
    repeat (70) step(1'b0, 32'h0, 1'b1);

    // Load colliding with the commit tick.
    run_to(3, 0);
    step(1'b1, 32'h55555555, 1'b1);
    run_to(7, DIV - 1);
    step(1'b1, 32'h33333333, 1'b1);
    repeat (80) step(1'b0, 32'h0, 1'b1);

    // Enable freeze mid-slot at digit 5.
    run_to(5, 2);
    repeat (10) step(1'b0, 32'h0, 1'b0);
    repeat (40) step(1'b0, 32'h0, 1'b1);

    // Async reset mid-frame with a pending value.
    run_to(0, 1);
    step(1'b1, 32'h77777777, 1'b1);
    run_to(3, 2);
    check("pre_reset_pending", {31'b0, pending}, 32'd1);
    @(posedge clock);
    #3;
    clear    = 1'b1;
    out_load = 1'b0;
    enable   = 1'b0;
    #1;
    check("mid_rst_an",      {24'b0, an},         32'hFF);
    check("mid_rst_seg",     {25'b0, seg},        32'h7F);
    check("mid_rst_dp",      {31'b0, dp},         32'd1);
    check("mid_rst_fd",      {31'b0, frame_done}, 32'd0);
    check("mid_rst_pending", {31'b0, pending},    32'd0);
    @(negedge clock);
    clear = 1'b0;
    reset_model();
    repeat (40) step(1'b0, 32'h0, 1'b1);

    // Randomized traffic, including random leading-zero widths.
    for (int i = 0; i < 3000; i++) begin
      logic        en;
      logic        ld;
      logic [31:0] d;
      en = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 24) == 0);
      d  = $urandom >> ($urandom_range(0, 8) * 4);
      step(ld, d, en);
    end

    repeat (3) @(negedge clock);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
